// File: rtl/spi_master_if.sv
// spi_master_if -- bus-side signal bundle for the SPI master.
//
// Carries the transfer request, configuration and serial lines between the
// peripheral-bus wrapper / SPI pins and spi_master.
//   master modport : the spi_master block itself
//                    (in: tx_start, tx_data, spi_config, miso;
//                     out: mosi, sclk, rx_data, busy)
//   slave modport  : the side that drives requests and observes results
//
// spi_config_t layout, MSB->LSB:
//   spi_mode[1:0]       bit1 = CPOL, bit0 = CPHA
//   spi_frame_size[1:0] 0 = 8 bit, 1 = 16 bit, 2/3 = 32 bit
//   prescaler[2:0]      half-period = 2^prescaler clk cycles
//   bit_order           0 = MSB first, 1 = LSB first
interface spi_master_if;

   typedef struct packed {
      logic [1:0] spi_mode;
      logic [1:0] spi_frame_size;
      logic [2:0] prescaler;
      logic       bit_order;
   } spi_config_t;

   logic        tx_start;
   logic [31:0] tx_data;
   spi_config_t spi_config;
   logic        miso;
   logic        mosi;
   logic        sclk;
   logic [31:0] rx_data;
   logic        busy;

   modport master (
      input  tx_start, tx_data, spi_config, miso,
      output mosi, sclk, rx_data, busy
   );

   modport slave (
      output tx_start, tx_data, spi_config, miso,
      input  mosi, sclk, rx_data, busy
   );

endinterface

// File: rtl/spi_master.sv
// spi_master -- single-channel SPI bus master.
//
// Serialises an 8/16/32-bit word onto mosi and captures miso into rx_data.
// SPI mode, frame size, SCLK prescaler and bit order are latched per transfer.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : spi_master_if.master (tx_start, tx_data, spi_config, miso in;
//          mosi, sclk, rx_data, busy out)
//
// Build option:
//   SPI_LSB_FIRST_EN  defined     -> bit_order selects MSB/LSB first
//                     not defined -> always MSB first, LSB path not built
//
// A transfer is 2N phases of H = 2^prescaler clk cycles. mosi changes on
// entry to even phases, miso is sampled on entry to odd phases, and sclk
// toggles on every phase boundary starting from CPOL^CPHA.
module spi_master (
   input  logic         clk,
   input  logic         rst,
   spi_master_if.master bus
);

   typedef enum logic {IDLE, XFER} state_t;

   typedef struct packed {
      logic [1:0] spi_mode;
      logic [1:0] spi_frame_size;
      logic [2:0] prescaler;
      logic       bit_order;
   } cfg_t;

   // left shift that puts bit N-1 of tx_data at bit 31
   function automatic logic [4:0] msb_align(input logic [1:0] fs);
      case (fs)
         2'd0:    msb_align = 5'd24;
         2'd1:    msb_align = 5'd16;
         default: msb_align = 5'd0;
      endcase
   endfunction

   // index of the final phase, 2N-1
   function automatic logic [5:0] last_phase(input logic [1:0] fs);
      case (fs)
         2'd0:    last_phase = 6'd15;
         2'd1:    last_phase = 6'd31;
         default: last_phase = 6'd63;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cfg_raw;
   cfg_t        cfg_live;

   logic        cpol_q;
   logic [1:0]  fs_q;
   logic [2:0]  psc_q;
   logic [5:0]  phase_q;
   logic [6:0]  cnt_q;
   logic [31:0] tx_sh_q;
   logic [31:0] rx_sh_q;
   logic        sclk_q;
   logic        mosi_q;
   logic [31:0] rx_data_q;

   logic [6:0]  h_m1;
   logic        h_last;
   logic        start, advance, done;

   logic [31:0] tx_load, tx_next, rx_next;
   logic        tx_load_bit, tx_next_bit;

   assign cfg_raw  = bus.spi_config;
   assign cfg_live = cfg_t'(cfg_raw);

   assign h_m1   = 7'((8'd1 << psc_q) - 8'd1);
   assign h_last = (cnt_q == h_m1);

   // ------------------------------------------------------------------
   // Shift-register data paths
   // ------------------------------------------------------------------
`ifdef SPI_LSB_FIRST_EN
   logic       lsb_q;
   logic [4:0] bit_idx;

   assign bit_idx     = phase_q[5:1];
   assign tx_load     = cfg_live.bit_order ? bus.tx_data
                                           : (bus.tx_data << msb_align(cfg_live.spi_frame_size));
   assign tx_load_bit = cfg_live.bit_order ? tx_load[0] : tx_load[31];
   assign tx_next     = lsb_q ? {1'b0, tx_sh_q[31:1]} : {tx_sh_q[30:0], 1'b0};
   assign tx_next_bit = lsb_q ? tx_next[0] : tx_next[31];

   // LSB first: bit i lands at position i; MSB first: shift in from the LSB
   always_comb begin
      rx_next = rx_sh_q;
      if (lsb_q) rx_next[bit_idx] = bus.miso;
      else       rx_next = {rx_sh_q[30:0], bus.miso};
   end
`else
   logic unused_bit_order;

   assign unused_bit_order = cfg_live.bit_order;
   assign tx_load     = bus.tx_data << msb_align(cfg_live.spi_frame_size);
   assign tx_load_bit = tx_load[31];
   assign tx_next     = {tx_sh_q[30:0], 1'b0};
   assign tx_next_bit = tx_next[31];
   assign rx_next     = {rx_sh_q[30:0], bus.miso};
`endif

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A start request present on the final edge of a frame restarts directly,
   // so back-to-back frames have no idle cycle between them.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      advance = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.tx_start) begin
               start   = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            if (h_last) begin
               advance = 1'b1;
               if (phase_q == last_phase(fs_q)) begin
                  done = 1'b1;
                  if (bus.tx_start) start   = 1'b1;
                  else              state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpol_q    <= 1'b0;
         fs_q      <= 2'd0;
         psc_q     <= 3'd0;
`ifdef SPI_LSB_FIRST_EN
         lsb_q     <= 1'b0;
`endif
         phase_q   <= 6'd0;
         cnt_q     <= 7'd0;
         tx_sh_q   <= 32'd0;
         rx_sh_q   <= 32'd0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         rx_data_q <= 32'd0;
      end else begin
         if (start) begin
            cpol_q  <= cfg_live.spi_mode[1];
            fs_q    <= cfg_live.spi_frame_size;
            psc_q   <= cfg_live.prescaler;
`ifdef SPI_LSB_FIRST_EN
            lsb_q   <= cfg_live.bit_order;
`endif
            phase_q <= 6'd0;
            cnt_q   <= 7'd0;
            tx_sh_q <= tx_load;
            mosi_q  <= tx_load_bit;
            // phase 0 level: CPOL for CPHA=0, !CPOL for CPHA=1
            sclk_q  <= cfg_live.spi_mode[1] ^ cfg_live.spi_mode[0];
            rx_sh_q <= 32'd0;
         end else if (state_q == IDLE) begin
            sclk_q <= cfg_live.spi_mode[1];
            mosi_q <= 1'b0;
         end else if (done) begin
            sclk_q <= cpol_q;
            mosi_q <= 1'b0;
         end else if (advance) begin
            phase_q <= phase_q + 6'd1;
            cnt_q   <= 7'd0;
            sclk_q  <= ~sclk_q;
            if (!phase_q[0]) begin
               rx_sh_q <= rx_next;        // entering odd phase: sample
            end else begin
               tx_sh_q <= tx_next;        // entering even phase: next bit
               mosi_q  <= tx_next_bit;
            end
         end else begin
            cnt_q <= cnt_q + 7'd1;
         end

         if (done) rx_data_q <= rx_sh_q;
      end
   end

   assign bus.busy    = (state_q == XFER);
   assign bus.mosi    = mosi_q;
   assign bus.sclk    = sclk_q;
   assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed self-checking bench for spi_master.
//
// Drives the slave side of spi_master_if, optionally loops mosi back to
// miso, and records mosi on every rising sclk plus a count of all sclk
// edges so that frame contents and edge counts can be compared against
// hand-computed values.
module tb_spi_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_master_if bus();

   spi_master dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic loopback;
   logic miso_val;
   always_comb bus.miso = loopback ? bus.mosi : miso_val;

   logic [63:0] mon_bits = '0;
   int          mon_cnt  = 0;
   int          edge_cnt = 0;

   always @(posedge bus.sclk) begin
      mon_bits <= {mon_bits[62:0], bus.mosi};
      mon_cnt  <= mon_cnt + 1;
   end

   always @(bus.sclk) edge_cnt <= edge_cnt + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one-cycle start pulse; returns at the negedge just after T0
   task automatic pulse_start();
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
   endtask

   // counts negedges with busy high, bounded
   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n, e0, m0, nb;
      logic [31:0] exp_slots;

      rst            = 1'b1;
      loopback       = 1'b0;
      miso_val       = 1'b0;
      bus.tx_start   = 1'b0;
      bus.tx_data    = 32'd0;
      bus.spi_config = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mosi", {31'd0, bus.mosi}, 32'd0);
      check("rst_sclk", {31'd0, bus.sclk}, 32'd0);
      check("rst_rx",   bus.rx_data,       32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // mode 0, 8 bit, PSC_2, miso tied high
      bus.tx_data = 32'h72;
      miso_val    = 1'b1;
      e0 = edge_cnt; m0 = mon_cnt;
      pulse_start();
      check("t1_busy_t0",  {31'd0, bus.busy}, 32'd1);
      check("t1_mosi_b7",  {31'd0, bus.mosi}, 32'd0);
      check("t1_sclk_ph0", {31'd0, bus.sclk}, 32'd0);
      count_busy(n);
      check("t1_busy_cycles", n, 32'd16);
      check("t1_rx",          bus.rx_data, 32'h0000_00FF);
      check("t1_mosi_bits",   {24'd0, mon_bits[7:0]}, 32'h72);
      check("t1_samples",     mon_cnt - m0, 32'd8);
      check("t1_sclk_edges",  edge_cnt - e0, 32'd16);
      check("t1_sclk_idle",   {31'd0, bus.sclk}, 32'd0);
      check("t1_mosi_idle",   {31'd0, bus.mosi}, 32'd0);

      // mode 3, 16 bit, PSC_8, loopback
      bus.spi_config = 8'hD4;
      repeat (2) @(negedge clk);
      check("t2_sclk_idle_hi", {31'd0, bus.sclk}, 32'd1);
      bus.tx_data = 32'hA5C3;
      loopback    = 1'b1;
      e0 = edge_cnt; m0 = mon_cnt;
      pulse_start();
      check("t2_sclk_ph0", {31'd0, bus.sclk}, 32'd0);
      check("t2_mosi_b15", {31'd0, bus.mosi}, 32'd1);
      count_busy(n);
      check("t2_busy_cycles", n, 32'd128);
      check("t2_rx",          bus.rx_data, 32'h0000_A5C3);
      check("t2_mosi_bits",   {16'd0, mon_bits[15:0]}, 32'hA5C3);
      check("t2_sclk_edges",  edge_cnt - e0, 32'd32);
      check("t2_sclk_idle",   {31'd0, bus.sclk}, 32'd1);

      // 32 bit, bit_order = LSB first, PSC_2, mode 0
      bus.spi_config = 8'h21;
      repeat (2) @(negedge clk);
      bus.tx_data = 32'h0000_0001;
      e0 = edge_cnt;
      pulse_start();
      count_busy(n);
`ifdef SPI_LSB_FIRST_EN
      exp_slots = 32'h8000_0000;
`else
      exp_slots = 32'h0000_0001;
`endif
      check("t3_busy_cycles", n, 32'd64);
      check("t3_slots",       mon_bits[31:0], exp_slots);
      check("t3_rx",          bus.rx_data, 32'h0000_0001);
      check("t3_sclk_edges",  edge_cnt - e0, 32'd64);

      // back-to-back: tx_start held through 0x12 then 0x34
      bus.spi_config = 8'h00;
      bus.tx_data    = 32'h12;
      @(negedge clk);
      e0 = edge_cnt;
      nb = 0;
      bus.tx_start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nb++;
         if (c == 3) begin
            bus.spi_config = 8'hD4;
            bus.tx_data    = 32'h99;
         end
         if (c == 8) begin
            bus.spi_config = 8'h00;
            bus.tx_data    = 32'h34;
         end
         if (c == 16) check("t4_rx_hold", bus.rx_data, 32'h1);
         if (c == 17) begin
            check("t4_no_gap",   {31'd0, bus.busy}, 32'd1);
            check("t4_rx_first", bus.rx_data, 32'h12);
            bus.tx_start = 1'b0;
         end
      end
      check("t4_busy_cycles", nb, 32'd32);
      check("t4_rx_second",   bus.rx_data, 32'h34);
      check("t4_mosi_bits",   {16'd0, mon_bits[15:0]}, 32'h1234);
      check("t4_sclk_edges",  edge_cnt - e0, 32'd32);
      check("t4_busy_end",    {31'd0, bus.busy}, 32'd0);

      // reset mid-transfer at phase 5, then a clean frame
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rx_cleared", bus.rx_data, 32'd0);
      @(negedge clk);
      bus.tx_data = 32'hA5;
      loopback    = 1'b0;
      miso_val    = 1'b1;
      pulse_start();
      repeat (5) @(negedge clk);
      check("t5_busy_ph5", {31'd0, bus.busy}, 32'd1);
      check("t5_sclk_ph5", {31'd0, bus.sclk}, 32'd1);
      check("t5_mosi_ph5", {31'd0, bus.mosi}, 32'd1);
      rst = 1'b1;
      #1;
      check("t5_busy_abort", {31'd0, bus.busy}, 32'd0);
      check("t5_sclk_abort", {31'd0, bus.sclk}, 32'd0);
      check("t5_mosi_abort", {31'd0, bus.mosi}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5_rx_kept", bus.rx_data, 32'd0);
      bus.tx_data = 32'h3C;
      loopback    = 1'b1;
      e0 = edge_cnt;
      pulse_start();
      count_busy(n);
      check("t5_busy_cycles", n, 32'd16);
      check("t5_rx",          bus.rx_data, 32'h3C);
      check("t5_mosi_bits",   {24'd0, mon_bits[7:0]}, 32'h3C);
      check("t5_sclk_edges",  edge_cnt - e0, 32'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
# spi_master

Single-channel SPI bus master for the RV32E SoC peripheral bus. It serialises a 8/16/32-bit word from `tx_data` onto `mosi` and captures `miso` into `rx_data`. SCLK polarity/phase (modes 0–3), frame size, SCLK prescaler and bit order are selectable per transfer. Chip-select generation is outside this block; the bus wrapper drives CS around `busy`.

## Interface
- No parameters. `spi_config_t` is a packed struct from `defines.vh`, 8 bits, MSB→LSB:
  - `spi_mode[1:0]`: `SPI_MODE_0..3`, bit1 = CPOL, bit0 = CPHA.
  - `spi_frame_size[1:0]`: `SPI_FRAME_SIZE_8`=0, `_16`=1, `_32`=2; 3 is treated as 32.
  - `prescaler[2:0]`: `PSC_2`=0 … `PSC_256`=7.
  - `bit_order`: `MSB_FIRST`=0, `LSB_FIRST`=1.
- Ports:
  - `clk` in 1: system clock; all logic on its rising edge.
  - `rst` in 1: reset, asynchronous, active-high.
  - `tx_start` in 1: start request, level-sensitive.
  - `tx_data` in 32: transmit word; low N bits used.
  - `spi_config` in `spi_config_t`: transfer configuration.
  - `miso` in 1: serial data from slave.
  - `mosi` out 1: serial data to slave.
  - `sclk` out 1: SPI clock.
  - `rx_data` out 32: last received frame, zero-extended.
  - `busy` out 1: transfer in progress.

## Operation
- States: IDLE and XFER.
- IDLE:
  - `sclk` = CPOL of the live `spi_config`, `mosi`=0, `busy`=0.
  - On a `clk` edge with `tx_start`=1, latch `tx_data`, `spi_config` and N (8/16/32), then enter XFER.
- XFER:
  - H = 2^(prescaler) clk cycles; 2N phases k=0..2N-1, each H cycles.
  - CPHA=0: `sclk` = CPOL in even phases, !CPOL in odd phases. Each even phase k drives data bit k/2 on `mosi`. `miso` is captured on entry to each odd phase (leading edge).
  - CPHA=1: `sclk` = !CPOL in even phases, CPOL in odd phases. Data bit k/2 is driven on entry to even phase k. `miso` is captured on entry to each odd phase (trailing edge).
  - Bit order: MSB_FIRST sends `tx_data[N-1]` first, and received bits shift in from the LSB. LSB_FIRST sends `tx_data[0]` first, and received bit i lands at position i.
  - After phase 2N-1, return to IDLE. `sclk` returns to CPOL (exactly 2N SCLK edges per transfer). `rx_data` ← received frame, upper 32-N bits zero.
- `tx_start` and `spi_config` changes during XFER are ignored.
- `tx_start` still high at the end of a transfer starts the next transfer on the following edge (back-to-back).
- `rx_data` holds its value until the next transfer completes.
- Reset values: `busy`=0, `mosi`=0, `sclk`=0, `rx_data`=0, state IDLE.
- Reset asserted mid-transfer aborts immediately; no `rx_data` update.

## Timing
- T0 = clk edge at which `tx_start`=1 is sampled in IDLE.
- `busy` rises at T0 and stays high exactly 2N·H cycles.
- Phase 0 begins at T0. For CPHA=0, the first `mosi` bit is valid from T0.
- The `miso` capture register samples on the same clk edge that moves `sclk` to its sampling level.
- `rx_data` is updated on the same edge that drops `busy`.
- Example: 8-bit, PSC_2 (H=1) → `busy` high for 16 cycles; SCLK = clk/2.

## Configuration
- `SPI_LSB_FIRST_EN` defined: `bit_order` honoured as above.
- Not defined: `bit_order` is ignored and all transfers are MSB-first; the LSB-first mux logic is omitted.

## Test plan
- Mode 0, 8-bit, PSC_2, `tx_data`=0x72, `miso`=1, one-cycle `tx_start` → `mosi` bits 0,1,1,1,0,0,1,0 on rising SCLK; `busy` 16 cycles; `rx_data`=0x000000FF; `sclk` idles low.
- Mode 3, 16-bit, PSC_8, `tx_data`=0xA5C3, slave loopback (`miso`=`mosi`) → `rx_data`=0x0000A5C3; `sclk` idles high; `busy` 128 cycles.
- 32-bit, LSB_FIRST (macro defined), `tx_data`=0x00000001 → `mosi` high only in the first bit slot; with the macro undefined, high only in the last slot.
- `tx_start` held high through two transfers (first 0x12, then 0x34) → back-to-back frames with no IDLE gap; `spi_config` changed mid-frame has no effect.
- `rst` pulsed at phase 5 of a transfer → `busy`, `sclk`, `mosi` = 0 at once; `rx_data` keeps 0; a new `tx_start` runs a full clean frame.
